// File: rtl/ysyx_22050368_alu_pkg.sv
// Shared ALU definitions: mode codes, arbiter state encoding and a small helper.
// Used by the ALU arbiter and usable by decode.
package ysyx_22050368_alu_pkg;

  localparam int ALU_MODE_W = 3;

  typedef enum logic [ALU_MODE_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_NOT = 3'd2,
    ALU_AND = 3'd3,
    ALU_OR  = 3'd4,
    ALU_XOR = 3'd5,
    ALU_SLT = 3'd6,
    ALU_EQ  = 3'd7
  } alu_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  function automatic logic [1:0] id_to_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ysyx_22050368_rr_arb2.sv
// Two-way arbiter producing a one-hot grant while grant_en is high.
// YSYX_22050368_ALU_ARB_RR_EN selects round-robin; otherwise requester 0 has fixed priority.
module ysyx_22050368_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] gnt
);

`ifdef YSYX_22050368_ALU_ARB_RR_EN
  // Most recently granted requester; reset to 1 so requester 0 wins the first contention.
  logic last;

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (grant_en && (|req)) begin
      last <= gnt[1];
    end
  end

  always_comb begin
    gnt = 2'b00;
    if (grant_en) begin
      if (&req) begin
        gnt = last ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  always_comb begin
    gnt = 2'b00;
    if (grant_en) begin
      gnt = req[0] ? 2'b01 : req;
    end
  end
`endif

endmodule

// File: rtl/ysyx_22050368_alu_arb.sv
// Shares one combinational ALU between two valid/ready requesters: grant, execute one
// cycle, hold the registered response until accepted. Arbitration mode: YSYX_22050368_ALU_ARB_RR_EN.
module ysyx_22050368_alu_arb #(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2*XLEN-1:0] req_op1,
  input  logic [2*XLEN-1:0] req_op2,
  input  logic [5:0]        req_mode,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [XLEN-1:0]   rsp_result,
  output logic              rsp_zero,
  output logic              rsp_ovf,
  output logic              alu_en,
  output logic [XLEN-1:0]   alu_op1,
  output logic [XLEN-1:0]   alu_op2,
  output logic [2:0]        alu_mode,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              alu_zero,
  input  logic              alu_ovf
);
  import ysyx_22050368_alu_pkg::*;

  arb_state_e      state_reg, state_next;
  logic [XLEN-1:0] op1_reg, op2_reg, result_reg;
  logic [2:0]      mode_reg;
  logic            grant_id_reg, zero_reg, ovf_reg;

  logic [XLEN-1:0] lane_op1  [2];
  logic [XLEN-1:0] lane_op2  [2];
  logic [2:0]      lane_mode [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      assign lane_op1[gi]  = req_op1[gi*XLEN +: XLEN];
      assign lane_op2[gi]  = req_op2[gi*XLEN +: XLEN];
      assign lane_mode[gi] = req_mode[gi*3 +: 3];
    end
  endgenerate

  // Gating with rst keeps a request in the reset cycle from being accepted.
  logic       grant_en;
  logic [1:0] gnt;
  logic       win;

  assign grant_en = (state_reg == ST_IDLE) && !rst;
  assign win      = gnt[1];
  assign req_ready = gnt;

  ysyx_22050368_rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req_valid),
    .grant_en (grant_en),
    .gnt      (gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (|gnt) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: if (rsp_ready[grant_id_reg]) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op1_reg      <= '0;
      op2_reg      <= '0;
      mode_reg     <= '0;
      grant_id_reg <= 1'b0;
      result_reg   <= '0;
      zero_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      if (|gnt) begin
        op1_reg      <= lane_op1[win];
        op2_reg      <= lane_op2[win];
        mode_reg     <= lane_mode[win];
        grant_id_reg <= win;
      end
      if (state_reg == ST_EXEC) begin
        result_reg <= alu_result;
        zero_reg   <= alu_zero;
        ovf_reg    <= alu_ovf;
      end
    end
  end

  always_comb begin
    alu_en    = 1'b0;
    rsp_valid = 2'b00;
    if (state_reg == ST_EXEC) alu_en = 1'b1;
    if (state_reg == ST_RESP) rsp_valid = id_to_onehot(grant_id_reg);
  end

  // Operand registers drive the ALU in every state so its inputs never glitch.
  assign alu_op1    = op1_reg;
  assign alu_op2    = op2_reg;
  assign alu_mode   = mode_reg;
  assign rsp_result = result_reg;
  assign rsp_zero   = zero_reg;
  assign rsp_ovf    = ovf_reg;

endmodule

// File: tb/tb_ysyx_22050368_alu_arb.sv
// Scoreboard bench for ysyx_22050368_alu_arb with a behavioural ALU and arbitration model.
// Build with or without YSYX_22050368_ALU_ARB_RR_EN; expectations follow the macro.
module tb_ysyx_22050368_alu_arb;
  localparam int XLEN = 64;
`ifdef YSYX_22050368_ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed { logic [63:0] r; logic z; logic o; } alu_out_t;
  typedef struct { logic [63:0] a; logic [63:0] b; logic [2:0] m; } item_t;
  typedef struct { logic id; alu_out_t v; } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic [1:0]        req_valid = 2'b00, req_ready;
  logic [2*XLEN-1:0] req_op1 = '0, req_op2 = '0;
  logic [5:0]        req_mode = '0;
  logic [1:0]        rsp_valid, rsp_ready = 2'b11;
  logic [XLEN-1:0]   rsp_result;
  logic              rsp_zero, rsp_ovf, alu_en;
  logic [XLEN-1:0]   alu_op1, alu_op2, alu_result;
  logic [2:0]        alu_mode;
  logic              alu_zero, alu_ovf;

  ysyx_22050368_alu_arb #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_mode(req_mode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf),
    .alu_en(alu_en), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_mode(alu_mode),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_ovf(alu_ovf)
  );

  // Arithmetic definition of the shared ALU (flags only for add/sub).
  function automatic alu_out_t ref_alu(input logic [63:0] a, input logic [63:0] b, input logic [2:0] m);
    alu_out_t o;
    o = '0;
    case (m)
      3'd0: begin o.r = a + b; o.z = (o.r == 0); o.o = (a[63] == b[63]) && (o.r[63] != a[63]); end
      3'd1: begin o.r = a - b; o.z = (o.r == 0); o.o = (a[63] != b[63]) && (o.r[63] != a[63]); end
      3'd2: o.r = ~a;
      3'd3: o.r = a & b;
      3'd4: o.r = a | b;
      3'd5: o.r = a ^ b;
      3'd6: o.r = {63'd0, ($signed(a) < $signed(b))};
      default: o.r = {63'd0, (a == b)};
    endcase
    return o;
  endfunction

  // External ALU stand-in; outside EXEC it returns junk so stray captures are visible.
  logic [63:0] junk = 64'hDEAD_BEEF_0BAD_F00D;
  always @(posedge clk) junk <= {$urandom, $urandom};
  always_comb begin
    alu_out_t t;
    t = ref_alu(alu_op1, alu_op2, alu_mode);
    if (alu_en) begin
      alu_result = t.r; alu_zero = t.z; alu_ovf = t.o;
    end else begin
      alu_result = junk; alu_zero = junk[0]; alu_ovf = junk[1];
    end
  end

  int total = 0, bad = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Model state
  int      cyc = 0;
  bit      busy = 0, prev_rst = 1;
  logic    gid = 1'b0, last_m = 1'b1;
  int      gcyc = 0;
  exp_t    exp_q[$];
  exp_t    held;
  logic    grant_log[$];
  int      rsp_cnt[2] = '{0, 0};
  alu_out_t last_rsp;
  logic [1:0] hs = 2'b00;

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [1:0] exp_gnt, exp_rv;
    logic w;
    exp_t e;
    cyc++;
    if (rst) begin
      check("ready_in_reset", {62'd0, req_ready}, 64'd0);
      busy = 0; exp_q.delete(); last_m = 1'b1; hs = 2'b00; prev_rst = 1;
    end else begin
      if (prev_rst) begin
        check("reset_result", rsp_result, 64'd0);
        check("reset_flags", {62'd0, rsp_zero, rsp_ovf}, 64'd0);
        check("reset_alu_en", {63'd0, alu_en}, 64'd0);
        check("reset_alu_ops", {61'd0, alu_mode} | alu_op1 | alu_op2, 64'd0);
        check("reset_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        prev_rst = 0;
      end
      exp_gnt = 2'b00;
      if (!busy) begin
        if (req_valid == 2'b11) exp_gnt = (RR && !last_m) ? 2'b10 : 2'b01;
        else exp_gnt = req_valid;
      end
      check("req_ready", {62'd0, req_ready}, {62'd0, exp_gnt});
      hs = req_ready & req_valid;
      if (exp_gnt != 2'b00) begin
        w = exp_gnt[1];
        e.id = w;
        e.v = ref_alu(req_op1[int'(w)*64 +: 64], req_op2[int'(w)*64 +: 64], req_mode[int'(w)*3 +: 3]);
        exp_q.push_back(e);
        busy = 1; gid = w; gcyc = cyc; last_m = w;
        grant_log.push_back(w);
        $display("grant id=%0d cyc=%0d", w, cyc);
      end
      check("alu_en", {63'd0, alu_en}, {63'd0, (busy && cyc == gcyc + 1)});
      exp_rv = (busy && cyc >= gcyc + 2) ? (gid ? 2'b10 : 2'b01) : 2'b00;
      check("rsp_valid", {62'd0, rsp_valid}, {62'd0, exp_rv});
      if (busy && cyc == gcyc + 2) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL scoreboard_empty actual=response required=none");
        end else begin
          held = exp_q.pop_front();
          check("rsp_id", {63'd0, gid}, {63'd0, held.id});
          check("rsp_result", rsp_result, held.v.r);
          check("rsp_flags", {62'd0, rsp_zero, rsp_ovf}, {62'd0, held.v.z, held.v.o});
        end
      end else if (busy && cyc > gcyc + 2) begin
        check("rsp_hold_result", rsp_result, held.v.r);
        check("rsp_hold_flags", {62'd0, rsp_zero, rsp_ovf}, {62'd0, held.v.z, held.v.o});
      end
      if (busy && cyc >= gcyc + 2 && rsp_ready[gid]) begin
        busy = 0;
        rsp_cnt[gid]++;
        last_rsp = '{r: rsp_result, z: rsp_zero, o: rsp_ovf};
        $display("rsp id=%0d result=%h zero=%b ovf=%b", gid, rsp_result, rsp_zero, rsp_ovf);
      end
    end
  end

  // Requester drivers: hold valid+payload until accepted, then load the next queued item.
  item_t     rq[2][$];
  logic [1:0] cur_valid = 2'b00;
  bit        gaps = 0, rsp_rand = 0;
  logic [1:0] rsp_fixed = 2'b11;
  always @(posedge clk) begin
    item_t it;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (cur_valid[i] && hs[i]) cur_valid[i] = 1'b0;
      if (!cur_valid[i] && rq[i].size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
        it = rq[i].pop_front();
        req_op1[i*64 +: 64] = it.a;
        req_op2[i*64 +: 64] = it.b;
        req_mode[i*3 +: 3]  = it.m;
        cur_valid[i] = 1'b1;
      end
    end
    req_valid = cur_valid;
    rsp_ready = rsp_rand ? 2'($urandom_range(0, 3)) : rsp_fixed;
  end

  task automatic push(input int id, input logic [63:0] a, input logic [63:0] b, input logic [2:0] m);
    item_t it;
    it.a = a; it.b = b; it.m = m;
    rq[id].push_back(it);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #2;
      if (rq[0].size() == 0 && rq[1].size() == 0 && cur_valid == 2'b00 && !busy) return;
    end
    total++; bad++;
    $display("FAIL wait_idle actual=timeout required=idle");
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [63:0] rnd_operand();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0: v = 64'd0;
      1: v = 64'h7FFF_FFFF_FFFF_FFFF;
      2: v = 64'h8000_0000_0000_0000;
      3: v = 64'($urandom_range(0, 15));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    logic exp_order[6];
    int c0;
    bit seen;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single request: 5 + 7
    push(0, 64'd5, 64'd7, 3'd0);
    wait_idle();
    check("single_result", last_rsp.r, 64'd12);
    check("single_flags", {62'd0, last_rsp.z, last_rsp.o}, 64'd0);

    // Contention after reset; req0 re-asserts immediately
    do_reset();
    grant_log.delete();
    push(0, 64'd3, 64'd3, 3'd1);
    push(1, 64'hF0, 64'h0F, 3'd5);
    push(0, 64'd1, 64'd2, 3'd0);
    wait_idle();
    check("contention_n", 64'(grant_log.size()), 64'd3);
    if (grant_log.size() == 3) begin
      check("contention_g0", {63'd0, grant_log[0]}, 64'd0);
      check("contention_g1", {63'd0, grant_log[1]}, RR ? 64'd1 : 64'd0);
      check("contention_g2", {63'd0, grant_log[2]}, RR ? 64'd0 : 64'd1);
    end

    // Backpressure on requester 1 with req0 pending
    rsp_fixed = 2'b01;
    push(1, 64'h1234, 64'h1, 3'd1);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = busy && gid;
    end
    check("bp_granted", {63'd0, seen}, 64'd1);
    push(0, 64'd9, 64'd9, 3'd7);
    repeat (7) @(negedge clk);
    check("bp_rsp_valid", {62'd0, rsp_valid}, 64'd2);
    check("bp_req_ready", {62'd0, req_ready}, 64'd0);
    @(posedge clk); #1 rsp_fixed = 2'b11;
    wait_idle();

    // Overflow / flag gating
    push(0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 3'd0);
    wait_idle();
    check("ovf_add", {62'd0, last_rsp.z, last_rsp.o}, 64'd1);
    check("ovf_add_result", last_rsp.r, 64'h8000_0000_0000_0000);
    push(0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 3'd3);
    wait_idle();
    check("and_flags", {62'd0, last_rsp.z, last_rsp.o}, 64'd0);

    // Reset during EXEC; a request from req1 arrives while reset is held
    c0 = rsp_cnt[0];
    push(0, 64'd1, 64'd1, 3'd0);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = busy;
    end
    @(posedge clk); #1 rst = 1'b1;
    push(1, 64'd2, 64'd2, 3'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_idle();
    check("discarded_rsp", 64'(rsp_cnt[0]), 64'(c0));

    // Fairness: both continuously valid
    do_reset();
    grant_log.delete();
    for (int i = 0; i < 6; i++) begin
      push(0, 64'(i), 64'd1, 3'd0);
      push(1, 64'(i), 64'd1, 3'd1);
    end
    wait_idle();
    for (int i = 0; i < 6; i++) exp_order[i] = RR ? logic'(i % 2) : 1'b0;
    check("fair_n", 64'(grant_log.size()), 64'd12);
    if (grant_log.size() >= 6)
      for (int i = 0; i < 6; i++) check($sformatf("fair_g%0d", i), {63'd0, grant_log[i]}, {63'd0, exp_order[i]});

    // Random traffic
    gaps = 1; rsp_rand = 1;
    for (int i = 0; i < 150; i++) push($urandom_range(0, 1), rnd_operand(), rnd_operand(), 3'($urandom_range(0, 7)));
    wait_idle();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22050368_alu_arb.md
# ysyx_22050368_alu_arb

Sequential arbiter and sequencer that shares the single combinational core ALU (`ysyx_22050368_alu`) between two requesters, e.g. the execute stage (requester 0) and the address/branch helper (requester 1). It grants one request at a time, registers the operands, and drives the ALU for exactly one cycle. It captures result and flags, then holds them in a response register until the granted requester accepts them. All traffic uses valid/ready handshakes.

## Interface
Parameters:
- `XLEN`, 64, operand/result width; must match the ALU.

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  2  per-requester request valid, bit i = requester i
- `req_ready`  out  2  per-requester request accept
- `req_op1`  in  2*XLEN  {req1, req0} operand 1
- `req_op2`  in  2*XLEN  {req1, req0} operand 2
- `req_mode`  in  6  {req1, req0} 3-bit ALU mode
- `rsp_valid`  out  2  per-requester response valid
- `rsp_ready`  in  2  per-requester response accept
- `rsp_result`  out  XLEN  registered result, shared by both requesters and qualified by `rsp_valid`
- `rsp_zero`  out  1  registered ALU zero flag
- `rsp_ovf`  out  1  registered ALU overflow flag
- `alu_en`, `alu_op1`, `alu_op2`, `alu_mode`  out  1/XLEN/XLEN/3  drive the ALU
- `alu_result`, `alu_zero`, `alu_ovf`  in  XLEN/1/1  from the ALU

## Operation
- States: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - If any `req_valid` is set, the arbiter picks winner g.
  - `req_ready[g]`=1 combinationally in the same cycle; `req_ready` for the loser is 0.
  - `op1/op2/mode` of g are captured into operand registers, and g is recorded as `grant_id`.
  - Next state is EXEC.
  - If no request is valid, all `req_ready`=0 and the block stays in IDLE.
- EXEC:
  - `alu_en`=1; `alu_op1/op2/mode` come from the operand registers.
  - `alu_result/zero/ovf` are captured into the response registers.
  - Next state is RESP. The EXEC duration is exactly one cycle.
- RESP:
  - `rsp_valid[grant_id]`=1; the other bit is 0.
  - Result and flags stay stable until `rsp_ready[grant_id]`=1.
  - On that handshake the next state is IDLE.
  - The `rsp_ready` of the non-granted requester is ignored.
- Outside EXEC: `alu_en`=0, and `alu_op1/op2/mode` still present the operand registers, so the ALU inputs never glitch.
- Flags are passed through unchanged. The ALU already gates zero/overflow to 0 for modes other than 0 (add) and 1 (sub).
- Round-robin:
  - A `last` register records the most recently granted requester.
  - When both requesters are valid, the one ≠ `last` wins.
  - When one requester is valid, it wins.
  - `last` updates on every grant.
- A requester must keep `req_valid` and its payload stable until `req_ready`. The block does not check this rule.

## Timing
- Request handshake in cycle N → EXEC in cycle N+1 → `rsp_valid` in cycle N+2, with data registered.
- Minimum initiation interval is 3 cycles. No new grant is issued in the RESP cycle that completes the handshake.
- Response backpressure stalls the block in RESP indefinitely. Requests from both requesters stay unaccepted during the stall.
- Reset values:
  - outputs: `req_ready`=0, `rsp_valid`=0, `rsp_result`=0, `rsp_zero`=0, `rsp_ovf`=0, `alu_en`=0
  - internal: operand registers=0, `alu_mode`=0, `grant_id`=0, `last`=1 (requester 0 wins the first contention)
- Reset asserted in EXEC or RESP: the block returns to IDLE on the next edge. The in-flight operation and its response are discarded, and no `rsp_valid` is produced.
- A request that arrives in the reset cycle is not accepted.

## Configuration
- `YSYX_22050368_ALU_ARB_RR_EN` defined: round-robin arbitration as described in Operation.
- Not defined: fixed priority, where requester 0 always wins contention. The `last` register is not implemented, and all other behaviour is identical.

## Structure
- Shared package `ysyx_22050368_alu_pkg`, also usable by decode:
  - ALU mode constants: ADD=0, SUB=1, NOT=2, AND=3, OR=4, XOR=5, SLT=6, EQ=7
  - 2-bit state encoding IDLE=0, EXEC=1, RESP=2
- Sub-module `ysyx_22050368_rr_arb2`: 2-way arbiter containing the `last` register.
  - Inputs: `req[1:0]`, `grant_en`.
  - Output: one-hot `gnt[1:0]`.
  - The `YSYX_22050368_ALU_ARB_RR_EN` macro is handled inside this sub-module.
- The ALU instance lives in the parent. This block only drives its ports.

## Test plan
- Single request: req0 ADD, op1=5, op2=7 → `req_ready[0]` in the handshake cycle N, `alu_en`=1 in N+1, `rsp_valid`=01 in N+2 with result=12, zero=0, ovf=0.
- Contention after reset: both valid, req0 SUB 3−3, req1 XOR 0xF0^0x0F:
  - req0 is served first with result=0, zero=1.
  - req1 is granted in the IDLE cycle after req0's response handshake, giving result=0xFF.
  - With the macro undefined and req0 re-asserted, req0 wins again.
- Backpressure: `rsp_ready[1]`=0 for 5 cycles in RESP → `rsp_valid` stays 10 and result stays stable. A pending req0 stays unaccepted with `req_ready`=00.
- Overflow: ADD, op1=op2=0x4000_0000_0000_0000 → ovf=1. The same operands with mode AND → ovf=0, zero=0.
- Reset mid-operation: assert `rst` during EXEC → next cycle is IDLE, `rsp_valid`=00, and no response ever appears for the discarded request.
- Round-robin fairness: both requesters continuously valid for 6 transactions → grant order 0,1,0,1,0,1 with the macro defined; 0,0,0,0,0,0 without it.
